// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
//
// Sequential multi-operand accumulator. Each accepted operand is folded into a
// redundant sum/carry pair with a single carry-save (3:2) layer, so the
// per-beat critical path is only one full-adder deep. When the last operand of
// a group arrives, the redundant pair is resolved into binary with a CHUNK-bit
// carry-propagate adder, one chunk per cycle, LSB chunk first.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (registered)
//   in_data    unsigned operand, WIDTH bits
//   in_last    marks final operand of a group, sampled with the beat
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   out_sum    resolved sum modulo 2^ACC_W (registered)
//   out_cnt    operands in the group, saturating at 2^EXT+1 (registered)
//   out_ovf    group held more than 2^EXT operands (registered)
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
    parameter int WIDTH = 16,
    parameter int EXT   = 4,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+EXT-1:0]   out_sum,
    output logic [EXT:0]           out_cnt,
    output logic                   out_ovf
);

    localparam int ACC_W   = WIDTH + EXT;
    localparam int NCH     = ACC_W / CHUNK;
    localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W   = EXT + 1;
    localparam int CNT_LIM = 2 ** EXT;
    localparam int CNT_MAX = CNT_LIM + 1;

    // The resolve stage walks whole chunks; a ragged top chunk is not supported.
    if ((ACC_W % CHUNK) != 0) begin : g_chunk_check
        $error("csa_accum_ctrl: ACC_W (%0d) must be divisible by CHUNK (%0d)", ACC_W, CHUNK);
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Carry-save helpers
    // ------------------------------------------------------------------
    function automatic logic [ACC_W-1:0] csa_sum(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c
    );
        return a ^ b ^ c;
    endfunction

    // Majority bits shifted up one place; the carry out of the MSB is
    // discarded, which is exactly the modulo-2^ACC_W wrap.
    function automatic logic [ACC_W-1:0] csa_carry(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b,
        input logic [ACC_W-1:0] c
    );
        return {((a[ACC_W-2:0] & b[ACC_W-2:0]) |
                 (a[ACC_W-2:0] & c[ACC_W-2:0]) |
                 (b[ACC_W-2:0] & c[ACC_W-2:0])), 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              state_r;
    state_t              state_s;

    logic [ACC_W-1:0]    sum_r;
    logic [ACC_W-1:0]    carry_r;
    logic [ACC_W-1:0]    res_r;
    logic [IDX_W-1:0]    idx_r;
    logic                cy_r;
    logic [CNT_W-1:0]    cnt_r;

    logic                in_ready_r;
    logic                out_valid_r;
    logic [ACC_W-1:0]    out_sum_r;
    logic [CNT_W-1:0]    out_cnt_r;
    logic                out_ovf_r;

    logic                beat_s;
    logic                out_hs_s;
    logic                idx_last_s;
    logic                in_ready_s;
    logic [ACC_W-1:0]    opnd_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [CHUNK-1:0]    s_chunk_s;
    logic [CHUNK-1:0]    c_chunk_s;
    logic [CHUNK:0]      chunk_add_s;

    assign beat_s     = in_valid && in_ready_r;
    assign out_hs_s   = out_valid_r && out_ready;
    assign idx_last_s = (idx_r == IDX_W'(NCH - 1));
    assign opnd_s     = {{EXT{1'b0}}, in_data};

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_sum    = out_sum_r;
    assign out_cnt    = out_cnt_r;
    assign out_ovf    = out_ovf_r;

    // Saturating operand counter increment.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r >= CNT_W'(CNT_MAX)) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // One chunk of the carry-propagate adder used during RESOLVE.
    always_comb begin
        s_chunk_s   = sum_r[int'(idx_r) * CHUNK +: CHUNK];
        c_chunk_s   = carry_r[int'(idx_r) * CHUNK +: CHUNK];
        chunk_add_s = {1'b0, s_chunk_s} + {1'b0, c_chunk_s} + {{CHUNK{1'b0}}, cy_r};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    state_s = in_last ? RESOLVE : ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s && in_last) begin
                    state_s = RESOLVE;
                end else begin
                    state_s = ACCUM;
                end
            end
            RESOLVE: begin
                if (idx_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RESOLVE;
                end
            end
            DONE: begin
                if (out_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode: in_ready is derived from the upcoming state so the
    // registered copy is correct in the cycle the state takes effect.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_s)
            IDLE:    in_ready_s = 1'b1;
            ACCUM:   in_ready_s = 1'b1;
            RESOLVE: in_ready_s = 1'b0;
            DONE:    in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Registered handshake output toward the producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: accumulation, resolution and result registers
    // ------------------------------------------------------------------
    // Redundant accumulator, resolver and result/handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= {ACC_W{1'b0}};
            carry_r     <= {ACC_W{1'b0}};
            res_r       <= {ACC_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            cy_r        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_sum_r   <= {ACC_W{1'b0}};
            out_cnt_r   <= {CNT_W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (beat_s) begin
                        sum_r   <= opnd_s;
                        carry_r <= {ACC_W{1'b0}};
                        cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        idx_r   <= {IDX_W{1'b0}};
                        cy_r    <= 1'b0;
                    end else begin
                        idx_r   <= {IDX_W{1'b0}};
                        cy_r    <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat_s) begin
                        sum_r   <= csa_sum(sum_r, carry_r, opnd_s);
                        carry_r <= csa_carry(sum_r, carry_r, opnd_s);
                        cnt_r   <= cnt_inc_s;
                    end else begin
                        sum_r   <= sum_r;
                        carry_r <= carry_r;
                    end
                end
                RESOLVE: begin
                    res_r[int'(idx_r) * CHUNK +: CHUNK] <= chunk_add_s[CHUNK-1:0];
                    if (idx_last_s) begin
                        // Carry out of the top chunk is the modulo wrap.
                        cy_r  <= 1'b0;
                        idx_r <= {IDX_W{1'b0}};
                    end else begin
                        cy_r  <= chunk_add_s[CHUNK];
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (!out_valid_r) begin
                        // First DONE cycle: publish the resolved group.
                        out_valid_r <= 1'b1;
                        out_sum_r   <= res_r;
                        out_cnt_r   <= cnt_r;
                        out_ovf_r   <= (cnt_r > CNT_W'(CNT_LIM));
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        sum_r       <= {ACC_W{1'b0}};
                        carry_r     <= {ACC_W{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_ctrl
//
// Directed, table-driven bench for csa_accum_ctrl with default parameters
// (WIDTH=16, EXT=4, CHUNK=4 -> ACC_W=20, NCH=5). Each table row describes an
// arithmetic operand group with hand-computed expected results; a few
// hand-written sequences cover result back-pressure and reset mid-resolve.
// ---------------------------------------------------------------------------
module tb_csa_accum_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sum;
    logic [4:0]  out_cnt;
    logic        out_ovf;

    int checks;
    int failures;
    int cyc;

    csa_accum_ctrl #(.WIDTH(16), .EXT(4), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          n;
        logic [15:0] first;
        logic [15:0] step;
        bit          gaps;
        logic [19:0] exp_sum;
        logic [4:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Send operands first, first+step, ...; returns the cycle of the last beat.
    task automatic send_group(input int n, input logic [15:0] first, input logic [15:0] step,
                              input bit gaps, output int t_last);
        int k;
        logic [15:0] v;
        v = first;
        t_last = cyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = v;
            in_last  = (i == n - 1);
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k >= 50) chk("beat_accept_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            t_last = cyc;
            v = v + step;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Offer a junk beat while waiting (must be ignored), check the result and
    // latency, then take it and check the handshake returns to IDLE.
    task automatic take_result(input string tag, input int t_last, input logic [19:0] es,
                               input logic [4:0] ec, input logic eo);
        int k;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        in_last  = 1'b1;
        k = 0;
        while (!out_valid && k < 30) begin
            chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        if (k >= 30) chk({tag, "_result_timeout"}, 32'd1, 32'd0);
        chk({tag, "_latency"}, 32'(cyc - t_last), 32'd6);
        chk({tag, "_sum"}, 32'(out_sum), 32'(es));
        chk({tag, "_cnt"}, 32'(out_cnt), 32'(ec));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int t;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{3,  16'd5,      16'd2,      1'b0, 20'd21,      5'd3,  1'b0};
        vecs[1] = '{1,  16'hABCD,   16'h0000,   1'b0, 20'h0ABCD,   5'd1,  1'b0};
        vecs[2] = '{16, 16'hFFFF,   16'h0000,   1'b0, 20'hFFFF0,   5'd16, 1'b0};
        vecs[3] = '{17, 16'hFFFF,   16'h0000,   1'b0, 20'h0FFEF,   5'd17, 1'b1};
        vecs[4] = '{10, 16'd1,      16'd1,      1'b1, 20'd55,      5'd10, 1'b0};
        vecs[5] = '{4,  16'h8000,   16'h1000,   1'b0, 20'h26000,   5'd4,  1'b0};

        // Reset state.
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cnt",   32'(out_cnt),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Table-driven groups.
        for (int v = 0; v < 6; v++) begin
            send_group(vecs[v].n, vecs[v].first, vecs[v].step, vecs[v].gaps, t);
            take_result($sformatf("vec%0d", v), t, vecs[v].exp_sum, vecs[v].exp_cnt, vecs[v].exp_ovf);
        end

        // Back-pressure: result held stable for 5 cycles with out_ready low.
        send_group(2, 16'd10, 16'd10, 1'b0, t);
        begin
            int k;
            k = 0;
            while (!out_valid && k < 30) begin
                @(negedge clk);
                k++;
            end
            if (k >= 30) chk("hold_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_sum",      32'(out_sum),   32'd30);
            chk("hold_cnt",      32'(out_cnt),   32'd2);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_valid_drop", 32'(out_valid), 32'd0);
        chk("hold_ready_back", 32'(in_ready),  32'd1);
        send_group(3, 16'd1, 16'd1, 1'b0, t);
        take_result("after_hold", t, 20'd6, 5'd3, 1'b0);

        // Reset asserted during the 3rd RESOLVE cycle.
        send_group(2, 16'd100, 16'd100, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sum",   32'(out_sum),   32'd0);
        chk("midrst_out_cnt",   32'(out_cnt),   32'd0);
        chk("midrst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_group(2, 16'd2, 16'd1, 1'b0, t);
        take_result("post_rst", t, 20'd5, 5'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
